// File: rtl/rtc_read_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus read controller.
package rtc_read_ctrl_pkg;

    localparam int unsigned T_PHASE_DEFAULT = 4;
    localparam int unsigned CNT_W           = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        TURN = 3'd2,
        READ = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/rtc_read_ctrl_phase_timer.sv
// Loadable down counter timing each bus phase; tc flags the final cycle.
module rtc_read_ctrl_phase_timer
    import rtc_read_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/rtc_read_ctrl.sv
// RTC register read: address phase, bus turnaround, read phase, one-cycle result.
module rtc_read_ctrl
    import rtc_read_ctrl_pkg::*;
#(
    parameter int unsigned T_PHASE = T_PHASE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a_d,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(T_PHASE - 1);

    state_t state;
    logic   load;
    logic   tc;

    rtc_read_ctrl_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (PHASE_LOAD),
        .tc       (tc)
    );

    always_comb begin
        load = 1'b0;
        case (state)
            IDLE:       load = start;
            ADDR, TURN: load = tc;
            default:    load = 1'b0;
        endcase
    end

    // Outputs are set on the edge entering each state so they are all registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ad_out     <= '0;
            ad_oe      <= 1'b0;
            cs_n       <= 1'b1;
            wr_n       <= 1'b1;
            rd_n       <= 1'b1;
            a_d        <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ADDR;
                        ad_out <= addr;
                        ad_oe  <= 1'b1;
                        cs_n   <= 1'b0;
                        wr_n   <= 1'b0;
                        a_d    <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                ADDR: begin
                    if (tc) begin
                        state <= TURN;
                        ad_oe <= 1'b0;
                        cs_n  <= 1'b1;
                        wr_n  <= 1'b1;
                        a_d   <= 1'b1;
                    end
                end
                TURN: begin
                    if (tc) begin
                        state <= READ;
                        cs_n  <= 1'b0;
                        rd_n  <= 1'b0;
                    end
                end
                READ: begin
                    if (tc) begin
                        state      <= DONE;
                        cs_n       <= 1'b1;
                        rd_n       <= 1'b1;
                        a_d        <= 1'b0;
                        data_out   <= ad_in;
                        data_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    ad_oe      <= 1'b0;
                    cs_n       <= 1'b1;
                    wr_n       <= 1'b1;
                    rd_n       <= 1'b1;
                    a_d        <= 1'b0;
                    data_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
